// File: rtl/sc_hold_arbiter_pkg.sv
// ============================================================================
// Module  : sc_hold_arbiter_pkg
// Brief   : State encodings and defaults shared by the hold arbiter slice.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package sc_hold_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_GRANT   = 2'b01;
    localparam logic [1:0] ST_TURN    = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    localparam int HOLD_MAX_DEFAULT = 5;

endpackage

`default_nettype wire

// File: rtl/sc_dff.sv
// ============================================================================
// Module  : sc_dff
// Brief   : Generic W-bit storage cell with synchronous active-low reset.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sc_dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sc_sat_cnt.sv
// ============================================================================
// Module  : sc_sat_cnt
// Brief   : CNT_W-bit counter that clears on clr and saturates at MAX.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sc_sat_cnt #(
    parameter int CNT_W = 3,
    parameter int MAX   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX);

    logic [CNT_W-1:0] w_cnt_nxt;

    // Saturation check precedes the increment so the count can never wrap.
    always_comb begin
        w_cnt_nxt = cnt;
        if (clr) begin
            w_cnt_nxt = '0;
        end else if (inc && (cnt != c_max)) begin
            w_cnt_nxt = cnt + CNT_W'(1);
        end
    end

    sc_dff #(
        .W       (CNT_W),
        .RST_VAL ('0)
    ) u_cnt_reg (
        .clk (clk),
        .rst (rst),
        .d   (w_cnt_nxt),
        .q   (cnt)
    );

endmodule

`default_nettype wire

// File: rtl/sc_hold_arbiter.sv
// ============================================================================
// Module  : sc_hold_arbiter
// Brief   : Round-robin arbiter with saturating hold counter and preemption.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sc_hold_arbiter
    import sc_hold_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int CNT_W    = 3,
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic [CNT_W-1:0] hold_cnt,
    output logic             expired,
    output logic             err
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [ID_W-1:0]  r_gnt_id;
    logic [ID_W-1:0]  w_gnt_id_nxt;
    logic             r_expired;
    logic             w_expired_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic [CNT_W-1:0] w_hold_cnt;
    logic [ID_W-1:0]  w_win;
    logic             w_bad;
    logic             w_owner_req;
    logic             w_competitor;
    logic             w_sat;

    assign w_bad        = (r_state == ST_ILLEGAL) || ((r_gnt & (r_gnt - N_REQ'(1))) != '0);
    assign w_owner_req  = req[r_gnt_id];
    assign w_competitor = |(req & ~r_gnt);
    assign w_sat        = (w_hold_cnt == CNT_W'(HOLD_MAX));

    // Rotating priority: first set request at or above the pointer, with wrap.
    always_comb begin
        automatic logic v_found = 1'b0;
        automatic int   v_idx   = 0;
        w_win = '0;
        for (int i = 0; i < N_REQ; i++) begin
            v_idx = (int'(r_ptr) + i) % N_REQ;
            if (!v_found && req[v_idx]) begin
                v_found = 1'b1;
                w_win   = ID_W'(v_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_expired <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_expired <= w_expired_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_bad) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (|req) w_state_nxt = ST_GRANT;
                ST_GRANT: if (!w_owner_req || (w_sat && w_competitor)) w_state_nxt = ST_TURN;
                ST_TURN:  w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_gnt_nxt     = '0;
        w_gnt_id_nxt  = '0;
        w_expired_nxt = 1'b0;
        w_ptr_nxt     = r_ptr;
        w_cnt_clr     = 1'b1;
        w_cnt_inc     = 1'b0;
        w_err_nxt     = r_err | w_bad;
        if (!w_bad) begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        w_gnt_nxt    = N_REQ'(1) << w_win;
                        w_gnt_id_nxt = w_win;
                        w_ptr_nxt    = ID_W'((int'(w_win) + 1) % N_REQ);
                    end
                end
                ST_GRANT: begin
                    if (!w_owner_req) begin
                        w_cnt_clr = 1'b1;
                    end else if (w_sat && w_competitor) begin
                        w_expired_nxt = 1'b1;
                    end else begin
                        w_gnt_nxt    = r_gnt;
                        w_gnt_id_nxt = r_gnt_id;
                        w_cnt_clr    = 1'b0;
                        w_cnt_inc    = 1'b1;
                    end
                end
                default: w_cnt_clr = 1'b1;
            endcase
        end
    end

    sc_sat_cnt #(
        .CNT_W (CNT_W),
        .MAX   (HOLD_MAX)
    ) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_cnt_clr),
        .inc (w_cnt_inc),
        .cnt (w_hold_cnt)
    );

    assign gnt      = r_gnt;
    assign gnt_id   = r_gnt_id;
    assign busy     = |r_gnt;
    assign hold_cnt = w_hold_cnt;
    assign expired  = r_expired;
    assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sc_hold_arbiter.sv
// ============================================================================
// Module  : tb_sc_hold_arbiter
// Brief   : Scoreboard bench for sc_hold_arbiter against a behavioural model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_sc_hold_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic [2:0] cnt;
        logic       exp;
        logic       busy;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic [2:0] hold_cnt;
    logic       expired;
    logic       err;

    sc_hold_arbiter #(
        .N_REQ    (4),
        .ID_W     (2),
        .CNT_W    (3),
        .HOLD_MAX (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .hold_cnt (hold_cnt),
        .expired  (expired),
        .err      (err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q_exp[$];
    int   q_order[$];
    int   q_gap[$];
    bit   r_record   = 0;
    bit   r_prev_bsy = 0;
    int   r_gap      = 0;
    int   r_exp_cnt  = 0;

    // Reference model state
    int         m_state = 0;
    int         m_ptr   = 0;
    int         m_id    = 0;
    int         m_cnt   = 0;
    logic [3:0] m_gnt   = '0;
    bit         m_exp   = 0;
    bit         m_err   = 0;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    task automatic model_step(input logic [3:0] r, input bit rst_n, input bit bad);
        int w;
        if (!rst_n) begin
            m_state = 0; m_ptr = 0; m_id = 0; m_cnt = 0; m_gnt = '0; m_exp = 0; m_err = 0;
            return;
        end
        m_exp = 0;
        if (bad || m_state == 3) begin
            m_err = 1; m_state = 0; m_gnt = '0; m_id = 0; m_cnt = 0;
        end else if (m_state == 0) begin
            if (r != 0) begin
                w = -1;
                for (int k = 0; k < 4; k++)
                    if (w < 0 && r[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                m_state = 1; m_gnt = 4'(1 << w); m_id = w; m_cnt = 0; m_ptr = (w + 1) % 4;
            end
        end else if (m_state == 1) begin
            if (!r[m_id]) begin
                m_state = 2; m_gnt = '0; m_id = 0; m_cnt = 0;
            end else if (m_cnt == 5 && (r & ~m_gnt) != 0) begin
                m_exp = 1; m_state = 2; m_gnt = '0; m_id = 0; m_cnt = 0;
            end else if (m_cnt < 5) begin
                m_cnt++;
            end
        end else begin
            m_state = 0;
        end
    endtask

    // One clock: drive at negedge, push the model's prediction, compare after the edge.
    task automatic drive(input logic [3:0] r, input bit rst_n, input bit bad);
        exp_t e;
        req = r;
        rst = rst_n;
        if (bad) force dut.r_state = 2'b11;
        model_step(r, rst_n, bad);
        q_exp.push_back({m_gnt, 2'(m_id), 3'(m_cnt), m_exp, (m_gnt != 0), m_err});
        @(posedge clk);
        #1;
        if (bad) release dut.r_state;
        e = q_exp.pop_front();
        check("gnt",      int'(gnt),      int'(e.gnt));
        check("gnt_id",   int'(gnt_id),   int'(e.id));
        check("hold_cnt", int'(hold_cnt), int'(e.cnt));
        check("expired",  int'(expired),  int'(e.exp));
        check("busy",     int'(busy),     int'(e.busy));
        check("err",      int'(err),      int'(e.err));
        if (expired) r_exp_cnt++;
        if (busy && !r_prev_bsy) begin
            if (r_record) begin
                q_order.push_back(int'(gnt_id));
                q_gap.push_back(r_gap);
            end
            r_gap = 0;
        end else if (!busy) begin
            r_gap++;
        end
        r_prev_bsy = busy;
        @(negedge clk);
    endtask

    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        clk = 0;
        rst = 0;
        req = '0;
        @(negedge clk);

        // Reset held with all requests asserted
        drive(4'b1111, 0, 0);
        drive(4'b1111, 0, 0);

        // Round robin, each owner dropping after one cycle
        r_record = 1;
        for (int c = 0; c < 15; c++) drive(4'hF & ~m_gnt, 1, 0);
        r_record = 0;
        check("rr_grants", q_order.size(), 5);
        for (int i = 0; i < 5 && i < q_order.size(); i++) check("rr_order", q_order[i], exp_order[i]);
        for (int i = 1; i < 5 && i < q_gap.size(); i++) check("rr_gap", q_gap[i], 2);
        drive(4'b0000, 1, 0);
        drive(4'b0000, 1, 0);

        // Single requester, saturating hold then release
        for (int c = 0; c < 9; c++) drive(4'b0100, 1, 0);
        for (int c = 0; c < 3; c++) drive(4'b0000, 1, 0);

        // Preemption of owner 1 by requester 3
        r_exp_cnt = 0;
        for (int c = 0; c < 3; c++) drive(4'b0010, 1, 0);
        for (int c = 0; c < 6; c++) drive(4'b1010, 1, 0);
        check("preempt_pulses", r_exp_cnt, 1);
        check("preempt_owner", int'(gnt), 4'b1000);
        for (int c = 0; c < 3; c++) drive(4'b0000, 1, 0);

        // Reset mid-grant
        for (int c = 0; c < 4; c++) drive(4'b0100, 1, 0);
        drive(4'b0110, 0, 0);
        drive(4'b0110, 1, 0);
        drive(4'b0110, 1, 0);
        for (int c = 0; c < 3; c++) drive(4'b0000, 1, 0);

        // Illegal state injection, err sticky until reset
        drive(4'b0000, 1, 1);
        for (int c = 0; c < 4; c++) drive(4'b0000, 1, 0);
        drive(4'b0000, 0, 0);
        drive(4'b0001, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sc_hold_arbiter.md
Name: sc_hold_arbiter

Overview:
- Round-robin arbiter granting one shared resource to N_REQ requesters.
- Each grant's tenure is tracked by an internal 3-bit saturating hold counter.
- A saturated owner is preempted when another requester is waiting.
- Sits between requesting units and the shared resource; exposes the hold count and an error flag for debug.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of gnt_id, equals clog2(N_REQ)
CNT_W, 3, hold counter width
HOLD_MAX, 5, saturation value of hold counter (must be < 2^CNT_W)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (rst==0 at a rising edge resets)
req  in  N_REQ  request per requester, level, held until served
gnt  out  N_REQ  one-hot grant, registered
gnt_id  out  ID_W  index of current owner, valid when busy=1, else 0
busy  out  1  resource currently granted (== |gnt)
hold_cnt  out  CNT_W  cycles owner has held grant, saturating
expired  out  1  one-cycle pulse, owner preempted
err  out  1  sticky illegal state / non-one-hot grant flag

Behaviour:
- Reset (rst==0 at clock edge): state=IDLE, gnt=0, gnt_id=0, busy=0, hold_cnt=0, expired=0, err=0, rr pointer=0. Reset overrides all other events, including mid-grant.
- States: IDLE, GRANT, TURN (one-cycle turnaround). Encoding 2 bits; code 2'b11 is illegal.
- IDLE: if |req, winner = first set req scanning from ptr upward with wrap (ptr, ptr+1, ..., N_REQ-1, 0, ...). Next cycle: state=GRANT, gnt=onehot(winner), gnt_id=winner, hold_cnt=0, ptr=winner+1 mod N_REQ. If req==0, stay IDLE.
- Latency: req rising in IDLE at edge t -> gnt high after edge t+1.
- GRANT, per cycle:
  - req[gnt_id]==0: release. gnt=0 next cycle, state=TURN, hold_cnt=0.
  - else if hold_cnt==HOLD_MAX and any other req set: preempt. gnt=0, expired=1 for exactly one cycle, state=TURN, hold_cnt=0.
  - else: stay GRANT; hold_cnt=min(hold_cnt+1, HOLD_MAX). Saturated with no competitor: hold_cnt stays HOLD_MAX, grant kept indefinitely.
- TURN: gnt=0 for one cycle, no arbitration; next state IDLE. Minimum gap between grants is 2 idle-grant cycles (TURN + IDLE arbitration).
- Simultaneous requests: resolved purely by rr pointer; the preempted owner is lowest priority next round because ptr already moved past it.
- Owner re-requesting: allowed; it competes normally in IDLE.
- err: set on illegal state code or gnt not one-hot/zero. When set: next state IDLE, gnt=0, hold_cnt=0. err stays 1 until reset.
- Output regs: gnt, gnt_id, expired, hold_cnt all driven from flops; busy = |gnt (combinational from flops).
- hold_cnt increment uses CNT_W-bit arithmetic; the compare against HOLD_MAX happens before the increment, so it never wraps.

Decomposition:
- Shared package/include: state encodings (ST_IDLE=2'b00, ST_GRANT=2'b01, ST_TURN=2'b10), default HOLD_MAX.
- Sub-module sc_sat_cnt: CNT_W-bit saturating counter with inputs clr and inc and parameter MAX, using the team's dff cell for storage.
- Round-robin pick is combinational inside the top.

Test Plan:
- Reset: drive rst=0 for 2 cycles with req=4'b1111 -> gnt=0, hold_cnt=0, err=0, busy=0. First grant after release of rst goes to requester 0.
- Single requester: req=4'b0100 from IDLE -> gnt=4'b0100, gnt_id=2 one cycle later. hold_cnt 0,1,2,3,4,5,5,5 while held. Drop req -> gnt=0 next cycle, TURN then IDLE.
- Round robin: req=4'b1111 held, each owner dropping after 1 cycle -> grant order 0,1,2,3,0 with exactly 2 gnt=0 cycles between grants.
- Preemption: owner 1 holds and req[3]=1 asserted at hold_cnt=2 -> at hold_cnt==5, expired pulses once, gnt=0 (TURN), then gnt=4'b1000.
- Reset mid-grant: owner 2 at hold_cnt=3, rst=0 for one edge -> all outputs 0 immediately after that edge, ptr=0, next grant to lowest set req.
- Error injection: force state=2'b11 -> err=1 next cycle, gnt=0, err remains 1 until rst=0.
